board_draw_sequencer: RTL and testbench
=======================================

// Module: board_draw_sequencer
// PURPOSE
//  Upstream of the per-digit number drawers (number1..number15) and downstream to the VGA adapter.
//  On start, snapshots the 4x4 board and visits cells in raster order (row 0 col 0 first).
//  Per cell: fills the tile background, then runs the selected drawer for a fixed window,
//  forwarding its pixels to the VGA adapter with the tile origin added.
// PARAMETERS
//  GRID_X0      22   x of top-left pixel of cell (0,0)
//  GRID_Y0      2    y of top-left pixel of cell (0,0)
//  TILE_PITCH   29   pixel step between adjacent cell origins
//  TILE_SIZE    28   filled square edge (1-pixel gap between tiles)
//  DRAW_CYCLES  141  drawer window length; one full drawer counter period
//  TILE_COLOUR  3'b110  BLANK_COLOUR 3'b000  TEXT_COLOUR 3'b001
// PORTS
//  clk          in   1   clock
//  resetn       in   1   synchronous, active-low reset
//  start        in   1   request a full board redraw; sampled only in IDLE
//  board        in   64  cell i = board[4i+3:4i], i = row*4+col; 0 = blank, 1..15 = tile number
//  drawer_x     in   8   x from the drawer selected by num_sel (drawer already adds tile_x)
//  drawer_y     in   7   y from the selected drawer
//  tile_x       out  8   current cell origin x, to drawer xIn
//  tile_y       out  7   current cell origin y, to drawer yIn
//  num_sel      out  4   drawer select = current cell value
//  num_en       out  1   drawer enable
//  num_resetn   out  1   drawer sync reset, active-low
//  vga_x        out  8   pixel x
//  vga_y        out  7   pixel y
//  vga_colour   out  3   pixel colour
//  vga_plot     out  1   pixel write strobe
//  busy         out  1   high from the cycle after start acceptance until done
//  done         out  1   one-cycle pulse at end of a redraw
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; num_resetn = 0 while resetn = 0. Reset mid-redraw aborts
//    with no done pulse.
//  - States: IDLE -> LOAD -> FILL -> [PREP -> DRAW] -> NEXT -> (FILL | BORDER | FIN) -> IDLE.
//  - IDLE: start = 1 -> LOAD. start is ignored in every other state.
//  - LOAD (1 cycle): latch board into snapshot; cell = 0. Later board changes are ignored.
//  - FILL (TILE_SIZE^2 cycles): scan fx, fy = 0..TILE_SIZE-1, fx fastest.
//    vga_x = tile_x + fx; vga_y = tile_y + fy; vga_plot = 1.
//    Colour = TILE_COLOUR if the cell is nonzero, else BLANK_COLOUR.
//  - Last FILL cycle: nonzero cell -> PREP; zero cell -> NEXT (drawer skipped).
//  - PREP (1 cycle): num_resetn = 0; vga_plot = 0.
//  - DRAW (DRAW_CYCLES cycles): num_en = 1; vga_x = drawer_x; vga_y = drawer_y;
//    colour TEXT_COLOUR; vga_plot = 1.
//  - NEXT (1 cycle): cell = 15 -> BORDER when enabled, else FIN; otherwise cell + 1 -> FILL.
//  - FIN (1 cycle): done = 1, busy = 0 -> IDLE.
//  - Tile origin: tile_x = GRID_X0 + col*TILE_PITCH; tile_y = GRID_Y0 + row*TILE_PITCH.
//    Computed as 8-bit/7-bit sums; parameters must keep all pixels within 160x120, no wrap logic.
//  - num_resetn = resetn & ~PREP. num_en is 0 outside DRAW. num_sel holds the cell value
//    from FILL through NEXT.
//  - Cycle count, start accepted at edge 0 -> done at edge
//    2 + 16*(TILE_SIZE^2 + 1) + Nnz*(1 + DRAW_CYCLES) [+ border],
//    where Nnz = number of nonzero cells.
// CONFIGURATION
//  BOARD_BORDER_EN defined: BORDER state after cell 15, before FIN.
//    Plots the 1-pixel outline of box x = GRID_X0-1 .. GRID_X0+4*TILE_PITCH,
//    y = GRID_Y0-1 .. GRID_Y0+4*TILE_PITCH, colour TEXT_COLOUR.
//    Edges drawn top, bottom, left, right, one pixel per cycle, L = 4*TILE_PITCH+2 cycles each;
//    corners are plotted twice.
//  Not defined: BORDER state absent; NEXT after cell 15 goes directly to FIN.
// TESTING
//  1. All-zero board, start pulse -> 16 fills in BLANK_COLOUR, num_en never 1,
//     done at edge 12562.
//  2. board = 64'h1 (cell 0 = 1) -> PREP at edge 786, num_resetn low 1 cycle,
//     141 DRAW plots, done at edge 12704.
//  3. Cell 5 = 12 -> tile_x = 51, tile_y = 31, num_sel = 12 in DRAW; first FILL pixel (51,31).
//  4. start held high and board changed mid-redraw -> no restart; pixels follow the LOAD
//     snapshot; exactly one done pulse.
//  5. resetn low during DRAW of cell 3 -> next cycle: IDLE, all outputs 0, no done;
//     a new start redraws from cell 0.
//  6. BOARD_BORDER_EN, all-zero board -> 4*118 extra plots at the box edges; done at edge 13034.

Source files
------------

// File: rtl/board_draw_sequencer.sv
// Redraws a 4x4 tile board: per cell, fill the tile background, then gate the digit drawer and forward its pixels.
// Define BOARD_BORDER_EN to add a 1-pixel outline around the grid after the last cell.
module board_draw_sequencer #(
    parameter int unsigned GRID_X0      = 22,
    parameter int unsigned GRID_Y0      = 2,
    parameter int unsigned TILE_PITCH   = 29,
    parameter int unsigned TILE_SIZE    = 28,
    parameter int unsigned DRAW_CYCLES  = 141,
    parameter logic [2:0]  TILE_COLOUR  = 3'b110,
    parameter logic [2:0]  BLANK_COLOUR = 3'b000,
    parameter logic [2:0]  TEXT_COLOUR  = 3'b001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [63:0] board_i,
    input  logic [7:0]  drawer_x_i,
    input  logic [6:0]  drawer_y_i,
    output logic [7:0]  tile_x_o,
    output logic [6:0]  tile_y_o,
    output logic [3:0]  num_sel_o,
    output logic        num_en_o,
    output logic        num_resetn_o,
    output logic [7:0]  vga_x_o,
    output logic [6:0]  vga_y_o,
    output logic [2:0]  vga_colour_o,
    output logic        vga_plot_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned FW       = $clog2(TILE_SIZE);
    localparam int unsigned EDGE_LEN = 4 * TILE_PITCH + 2;
    localparam int unsigned CNT_MAX  = (DRAW_CYCLES > EDGE_LEN) ? DRAW_CYCLES : EDGE_LEN;
    localparam int unsigned CW       = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILL, S_PREP, S_DRAW, S_NEXT, S_BORDER, S_FIN
    } state_t;

    state_t         state_q;
    logic [63:0]    snap_q;
    logic [3:0]     cell_q;
    logic [FW-1:0]  fx_q;
    logic [FW-1:0]  fy_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     tile_x_q;
    logic [6:0]     tile_y_q;
    logic [3:0]     num_sel_q;
    logic           busy_q;
    logic           done_q;
`ifdef BOARD_BORDER_EN
    logic [1:0]     side_q;
`endif

    // Origin and value of the following cell in raster order
    logic [3:0] cell_d;
    logic [7:0] tile_x_d;
    logic [6:0] tile_y_d;
    assign cell_d   = cell_q + 4'd1;
    assign tile_x_d = 8'(GRID_X0 + TILE_PITCH * 32'(cell_d[1:0]));
    assign tile_y_d = 7'(GRID_Y0 + TILE_PITCH * 32'(cell_d[3:2]));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            cell_q    <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            cnt_q     <= '0;
            tile_x_q  <= '0;
            tile_y_q  <= '0;
            num_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BOARD_BORDER_EN
            side_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    snap_q    <= board_i;
                    cell_q    <= '0;
                    fx_q      <= '0;
                    fy_q      <= '0;
                    tile_x_q  <= 8'(GRID_X0);
                    tile_y_q  <= 7'(GRID_Y0);
                    num_sel_q <= board_i[3:0];
                    state_q   <= S_FILL;
                end
                S_FILL: begin
                    if (fx_q == FW'(TILE_SIZE - 1)) begin
                        fx_q <= '0;
                        if (fy_q == FW'(TILE_SIZE - 1)) begin
                            fy_q    <= '0;
                            state_q <= (num_sel_q != 4'd0) ? S_PREP : S_NEXT;
                        end else begin
                            fy_q <= fy_q + FW'(1);
                        end
                    end else begin
                        fx_q <= fx_q + FW'(1);
                    end
                end
                S_PREP: begin
                    cnt_q   <= '0;
                    state_q <= S_DRAW;
                end
                S_DRAW: begin
                    if (cnt_q == CW'(DRAW_CYCLES - 1)) begin
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_NEXT: begin
                    if (cell_q == 4'd15) begin
`ifdef BOARD_BORDER_EN
                        cnt_q   <= '0;
                        side_q  <= '0;
                        state_q <= S_BORDER;
`else
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cell_q    <= cell_d;
                        tile_x_q  <= tile_x_d;
                        tile_y_q  <= tile_y_d;
                        num_sel_q <= snap_q[{cell_d, 2'b00} +: 4];
                        state_q   <= S_FILL;
                    end
                end
`ifdef BOARD_BORDER_EN
                // Four edges in order top, bottom, left, right
                S_BORDER: begin
                    if (cnt_q == CW'(EDGE_LEN - 1)) begin
                        cnt_q <= '0;
                        if (side_q == 2'd3) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            side_q <= side_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Pixel port decode; DRAW passes the drawer coordinates straight through
    always_comb begin
        vga_x_o      = '0;
        vga_y_o      = '0;
        vga_colour_o = '0;
        vga_plot_o   = 1'b0;
        num_en_o     = 1'b0;
        case (state_q)
            S_FILL: begin
                vga_x_o      = tile_x_q + 8'(fx_q);
                vga_y_o      = tile_y_q + 7'(fy_q);
                vga_colour_o = (num_sel_q != 4'd0) ? TILE_COLOUR : BLANK_COLOUR;
                vga_plot_o   = 1'b1;
            end
            S_DRAW: begin
                num_en_o     = 1'b1;
                vga_x_o      = drawer_x_i;
                vga_y_o      = drawer_y_i;
                vga_colour_o = TEXT_COLOUR;
                vga_plot_o   = 1'b1;
            end
`ifdef BOARD_BORDER_EN
            S_BORDER: begin
                vga_colour_o = TEXT_COLOUR;
                vga_plot_o   = 1'b1;
                case (side_q)
                    2'd0: begin
                        vga_x_o = 8'(GRID_X0 - 1) + 8'(cnt_q);
                        vga_y_o = 7'(GRID_Y0 - 1);
                    end
                    2'd1: begin
                        vga_x_o = 8'(GRID_X0 - 1) + 8'(cnt_q);
                        vga_y_o = 7'(GRID_Y0 + 4 * TILE_PITCH);
                    end
                    2'd2: begin
                        vga_x_o = 8'(GRID_X0 - 1);
                        vga_y_o = 7'(GRID_Y0 - 1) + 7'(cnt_q);
                    end
                    default: begin
                        vga_x_o = 8'(GRID_X0 + 4 * TILE_PITCH);
                        vga_y_o = 7'(GRID_Y0 - 1) + 7'(cnt_q);
                    end
                endcase
            end
`endif
            default: ;
        endcase
    end

    assign num_resetn_o = resetn & (state_q != S_PREP);
    assign tile_x_o     = tile_x_q;
    assign tile_y_o     = tile_y_q;
    assign num_sel_o    = num_sel_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Self-checking bench for board_draw_sequencer: table-driven full redraws plus reset/restart sequences.
module tb_board_draw_sequencer;

`ifdef BOARD_BORDER_EN
    localparam int BORDER_PLOTS = 472;
`else
    localparam int BORDER_PLOTS = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [63:0] board;
    logic [7:0]  drawer_x;
    logic [6:0]  drawer_y;
    logic [7:0]  tile_x;
    logic [6:0]  tile_y;
    logic [3:0]  num_sel;
    logic        num_en;
    logic        num_resetn;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    board_draw_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_i      (start),
        .board_i      (board),
        .drawer_x_i   (drawer_x),
        .drawer_y_i   (drawer_y),
        .tile_x_o     (tile_x),
        .tile_y_o     (tile_y),
        .num_sel_o    (num_sel),
        .num_en_o     (num_en),
        .num_resetn_o (num_resetn),
        .vga_x_o      (vga_x),
        .vga_y_o      (vga_y),
        .vga_colour_o (vga_colour),
        .vga_plot_o   (vga_plot),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Stand-in drawer: wanders around the tile origin it is given
    logic [7:0] dcnt = 8'd0;
    always @(posedge clk) dcnt <= dcnt + 8'd1;
    assign drawer_x = tile_x + (dcnt % 8'd13);
    assign drawer_y = tile_y + 7'(dcnt % 8'd11);

    logic [40:0] outs_no_nr;
    assign outs_no_nr = {tile_x, tile_y, num_sel, num_en, vga_x, vga_y, vga_colour, vga_plot, busy, done};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    logic [63:0] snap;
    function automatic logic [3:0] nib(input int c);
        logic [63:0] t;
        t = snap >> (4 * c);
        return t[3:0];
    endfunction
    function automatic int ox(input int c);
        return 22 + 29 * (c % 4);
    endfunction
    function automatic int oy(input int c);
        return 2 + 29 * (c / 4);
    endfunction

    int done_edge, done_cnt, fill_plots, draw_plots, border_plots, prep_cnt, first_prep;
    int fill_bad, draw_bad, busy_bad, fill_cell, fill_idx;
    bit         fd_seen;
    logic [3:0] fd_sel;
    logic [7:0] fd_tx;
    logic [6:0] fd_ty;

    // One full redraw, scored against a bench model of the raster scan
    task automatic run_redraw(input logic [63:0] brd, input bit hold, input int budget);
        int c, ex, ey;
        logic [2:0] ecol;
        done_edge = -1; done_cnt = 0; fill_plots = 0; draw_plots = 0; border_plots = 0;
        prep_cnt = 0; first_prep = -1; fill_bad = 0; draw_bad = 0; busy_bad = 0;
        fill_cell = 0; fill_idx = 0; fd_seen = 0; fd_sel = '0; fd_tx = '0; fd_ty = '0;
        @(negedge clk);
        board = brd;
        start = 1'b1;
        @(posedge clk);
        snap = brd;
        #1;
        if (!hold) start = 1'b0;
        for (int e = 1; e <= budget; e++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    if (hold) start = 1'b0;
                end
            end
            if (busy !== (done_edge < 0)) busy_bad++;
            if (!num_resetn) begin
                prep_cnt++;
                if (first_prep < 0) first_prep = e;
                if (vga_plot || num_en) draw_bad++;
            end
            if (num_en && !vga_plot) draw_bad++;
            if (vga_plot) begin
                if (num_en) begin
                    draw_plots++;
                    c = fill_cell - 1;
                    if (c < 0) draw_bad++;
                    else if (vga_x !== drawer_x || vga_y !== drawer_y || vga_colour !== 3'b001 ||
                             num_sel !== nib(c) || tile_x !== 8'(ox(c)) || tile_y !== 7'(oy(c)))
                        draw_bad++;
                    if (!fd_seen) begin
                        fd_seen = 1;
                        fd_sel  = num_sel;
                        fd_tx   = tile_x;
                        fd_ty   = tile_y;
                    end
                end else if (vga_colour == 3'b001) begin
                    border_plots++;
                    if (!(vga_x == 8'd21 || vga_x == 8'd138 || vga_y == 7'd1 || vga_y == 7'd118))
                        draw_bad++;
                end else begin
                    fill_plots++;
                    if (fill_cell > 15) fill_bad++;
                    else begin
                        ex   = ox(fill_cell) + fill_idx % 28;
                        ey   = oy(fill_cell) + fill_idx / 28;
                        ecol = (nib(fill_cell) != 4'd0) ? 3'b110 : 3'b000;
                        if (vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== ecol) fill_bad++;
                        fill_idx++;
                        if (fill_idx == 784) begin
                            fill_idx = 0;
                            fill_cell++;
                        end
                    end
                end
            end
            if (hold && e == 3) board = ~brd;
            if (done_edge >= 0 && e >= done_edge + 20) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [63:0] board;
        bit          hold;
        int          exp_done;
        int          exp_nnz;
        int          exp_prep;
        logic [3:0]  exp_sel;
        logic [7:0]  exp_tx;
        logic [6:0]  exp_ty;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int   dn, bz;
        bit   found;
        string p;

        vecs[0] = '{64'h0,                   1'b0, 12562,  0, -1,   4'd0,  8'd0,  7'd0};
        vecs[1] = '{64'h1,                   1'b0, 12704,  1, 786,  4'd1,  8'd22, 7'd2};
        vecs[2] = '{64'h0000_0000_00C0_0000, 1'b1, 12704,  1, 4711, 4'd12, 8'd51, 7'd31};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 1'b0, 14692, 15, 786,  4'd15, 8'd22, 7'd2};

        resetn = 1'b0;
        start  = 1'b0;
        board  = '0;
        snap   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_no_nr, 0);
        check("reset_num_resetn", num_resetn, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_outputs", outs_no_nr, 0);
        check("idle_num_resetn", num_resetn, 1);

        for (int i = 0; i < 4; i++) begin
            p = $sformatf("rec%0d_", i);
            run_redraw(vecs[i].board, vecs[i].hold, vecs[i].exp_done + BORDER_PLOTS + 40);
            check({p, "done_edge"},       done_edge,    vecs[i].exp_done + BORDER_PLOTS);
            check({p, "done_pulses"},     done_cnt,     1);
            check({p, "busy_errors"},     busy_bad,     0);
            check({p, "fill_plots"},      fill_plots,   16 * 784);
            check({p, "fill_errors"},     fill_bad,     0);
            check({p, "draw_plots"},      draw_plots,   vecs[i].exp_nnz * 141);
            check({p, "draw_errors"},     draw_bad,     0);
            check({p, "prep_cycles"},     prep_cnt,     vecs[i].exp_nnz);
            check({p, "first_prep_edge"}, first_prep,   vecs[i].exp_prep);
            check({p, "border_plots"},    border_plots, BORDER_PLOTS);
            check({p, "first_draw_sel"},  fd_sel,       vecs[i].exp_sel);
            check({p, "first_draw_tile"}, {fd_tx, fd_ty}, {vecs[i].exp_tx, vecs[i].exp_ty});
        end

        // Reset while drawing cell 3 aborts, then a fresh start begins at cell 0
        board = 64'h0000_0000_0000_7000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int e = 0; e < 4000 && !found; e++) begin
            @(negedge clk);
            if (num_en && num_sel == 4'd7) found = 1;
        end
        check("abort_reached_draw_cell3", found, 1);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_outputs_zero", outs_no_nr, 0);
        check("abort_num_resetn_low", num_resetn, 0);
        @(negedge clk);
        resetn = 1'b1;
        dn = 0;
        bz = 0;
        for (int e = 0; e < 50; e++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bz++;
        end
        check("abort_no_done", dn, 0);
        check("abort_idle_not_busy", bz, 0);

        board = 64'h5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("restart_load_busy_noplot", {busy, vga_plot}, 2'b10);
        @(negedge clk);
        check("restart_first_fill_pixel", {vga_plot, vga_x, vga_y, vga_colour},
              {1'b1, 8'd22, 7'd2, 3'b110});
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
